// File: rtl/spdif_bmc_decoder.sv
// spdif_bmc_decoder: oversampling biphase-mark decoder with B/M/W preamble framing,
// per-subframe parity check and clean-subframe lock tracking.
module spdif_bmc_decoder #(
    parameter int SHORT_MIN  = 3,
    parameter int SHORT_MAX  = 9,
    parameter int MEDIUM_MAX = 16,
    parameter int LONG_MAX   = 24,
    parameter int LOCK_COUNT = 4
) (
    input  logic        i_sys_clk,
    input  logic        i_sys_rst_n,
    input  logic        i_spdif,
    output logic        o_sf_valid,
    output logic [27:0] o_sf_data,
    output logic [1:0]  o_sf_pre,
    output logic        o_sf_parity_err,
    output logic        o_locked,
    output logic        o_err
);
    typedef enum logic [1:0] {HUNT, PRE, DATA} state_t;
    typedef enum logic [1:0] {C_S, C_M, C_L, C_X} cls_t;
    localparam int LW = $clog2(LOCK_COUNT + 1);
    localparam logic [5:0] PAT_B = {C_S, C_S, C_L};
    localparam logic [5:0] PAT_M = {C_L, C_S, C_S};
    localparam logic [5:0] PAT_W = {C_M, C_S, C_M};

    state_t        st_q, st_d;
    cls_t          c1_q, c1_d, c2_q, c2_d, cls;
    logic          s1_q, s2_q, s3_q, edge_w, glitch, timeout, bad, done;
    logic [7:0]    cnt_q, cnt_d;
    logic [1:0]    pidx_q, pidx_d, type_q, type_d, pre_d;
    logic          half_q, half_d, valid_d, perr_d, locked_d, err_d;
    logic [4:0]    bit_q, bit_d;
    logic [27:0]   sr_q, sr_d, data_d;
    logic [LW-1:0] lock_q, lock_d;
    logic [5:0]    seq;

    assign edge_w  = s2_q ^ s3_q;
    assign glitch  = edge_w && cnt_q < 8'(SHORT_MIN);
    assign timeout = !edge_w && cnt_q == 8'(LONG_MAX);
    assign cnt_d   = edge_w ? 8'd1 : cnt_q == 8'(LONG_MAX + 1) ? cnt_q : cnt_q + 8'd1;
    assign cls     = cnt_q <= 8'(SHORT_MAX) ? C_S : cnt_q <= 8'(MEDIUM_MAX) ? C_M :
                     cnt_q <= 8'(LONG_MAX) ? C_L : C_X;
    assign seq     = {c1_q, c2_q, cls};

    always_comb begin
        st_d = st_q;
        pidx_d = pidx_q;
        c1_d = c1_q;
        c2_d = c2_q;
        type_d = type_q;
        half_d = half_q;
        bit_d = bit_q;
        sr_d = sr_q;
        lock_d = lock_q;
        valid_d = 1'b0;
        err_d = 1'b0;
        data_d = o_sf_data;
        pre_d = o_sf_pre;
        perr_d = o_sf_parity_err;
        locked_d = o_locked;
        bad = glitch || timeout;
        done = 1'b0;
        if (edge_w && !glitch) begin
            if (st_q == HUNT) begin
                st_d = cls == C_L ? PRE : HUNT;
                pidx_d = 2'd1;
            end else if (st_q == PRE) begin
                // pulse 0 is the L that opened the preamble; only pulses 1..3 are kept
                pidx_d = pidx_q + 2'd1;
                c1_d = c2_q;
                c2_d = cls;
                if (pidx_q == 2'd0) begin
                    bad = cls != C_L;
                end else if (pidx_q == 2'd3) begin
                    bad = seq != PAT_B && seq != PAT_M && seq != PAT_W;
                    type_d = seq == PAT_B ? 2'd0 : seq == PAT_M ? 2'd1 : 2'd2;
                    st_d = DATA;
                    bit_d = 5'd0;
                    half_d = 1'b0;
                end
            end else if (cls == C_S && !half_q) begin
                half_d = 1'b1;
            end else if (cls == C_S || (cls == C_M && !half_q)) begin
                half_d = 1'b0;
                sr_d = {cls == C_S, sr_q[27:1]};
                bit_d = bit_q + 5'd1;
                done = bit_q == 5'd27;
            end else begin
                bad = 1'b1;
            end
        end
        if (done) begin
            valid_d = 1'b1;
            data_d = sr_d;
            pre_d = type_q;
            perr_d = ^sr_d;
            lock_d = perr_d ? '0 : lock_q == LW'(LOCK_COUNT) ? lock_q : lock_q + LW'(1);
            locked_d = o_locked || lock_d == LW'(LOCK_COUNT);
            st_d = PRE;
            pidx_d = 2'd0;
        end
        if (bad) begin
            st_d = HUNT;
            err_d = 1'b1;
            lock_d = '0;
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            {s1_q, s2_q, s3_q} <= 3'b000;
            st_q <= HUNT;
            c1_q <= C_S;
            c2_q <= C_S;
            cnt_q <= '0;
            pidx_q <= '0;
            type_q <= '0;
            half_q <= 1'b0;
            bit_q <= '0;
            sr_q <= '0;
            lock_q <= '0;
            o_sf_valid <= 1'b0;
            o_sf_data <= '0;
            o_sf_pre <= '0;
            o_sf_parity_err <= 1'b0;
            o_locked <= 1'b0;
            o_err <= 1'b0;
        end else begin
            {s1_q, s2_q, s3_q} <= {i_spdif, s1_q, s2_q};
            st_q <= st_d;
            c1_q <= c1_d;
            c2_q <= c2_d;
            cnt_q <= cnt_d;
            pidx_q <= pidx_d;
            type_q <= type_d;
            half_q <= half_d;
            bit_q <= bit_d;
            sr_q <= sr_d;
            lock_q <= lock_d;
            o_sf_valid <= valid_d;
            o_sf_data <= data_d;
            o_sf_pre <= pre_d;
            o_sf_parity_err <= perr_d;
            o_locked <= locked_d;
            o_err <= err_d;
        end
    end
endmodule
